// File: rtl/wb_arbiter_pkg.sv
// Shared types and sizing for the regfile write-port arbiter.
// Imported by the FIFO, the interface and the arbiter top.
package wb_arbiter_pkg;

  localparam int REG_IDX_W     = 5;
  localparam int XLEN          = 32;
  localparam int NUM_REGS      = 32;
  localparam int WB_FIFO_DEPTH = 2;
  localparam int MDU_MAX_OUTST = 4;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]      xdata_t;

  typedef struct packed {
    reg_idx_t idx;
    xdata_t   data;
  } wb_entry_t;

  function automatic logic is_x0(reg_idx_t i);
    return i == '0;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Write-port arbiter bus: pipeline WB, MDU issue/result,
// ID hazard query and regfile write port.
interface wb_arbiter_if;
  import wb_arbiter_pkg::*;

  logic     pipe_wb_en;
  reg_idx_t pipe_wb_idx;
  xdata_t   pipe_wb_data;

  logic     mdu_issue;
  reg_idx_t mdu_issue_idx;

  logic     mdu_res_valid;
  logic     mdu_res_ready;
  reg_idx_t mdu_res_idx;
  xdata_t   mdu_res_data;

  logic     id_rs1_en;
  logic     id_rs2_en;
  logic     id_rd_en;
  reg_idx_t id_rs1_idx;
  reg_idx_t id_rs2_idx;
  reg_idx_t id_rd_idx;
  logic     id_mdu;

  logic     wb_rd_en;
  reg_idx_t wb_rd_idx;
  xdata_t   wb_rd_data;
  logic     stall;

  modport master (
    output pipe_wb_en, pipe_wb_idx, pipe_wb_data,
    output mdu_issue, mdu_issue_idx,
    output mdu_res_valid, mdu_res_idx, mdu_res_data,
    input  mdu_res_ready,
    output id_rs1_en, id_rs2_en, id_rd_en,
    output id_rs1_idx, id_rs2_idx, id_rd_idx, id_mdu,
    input  wb_rd_en, wb_rd_idx, wb_rd_data, stall
  );

  modport slave (
    input  pipe_wb_en, pipe_wb_idx, pipe_wb_data,
    input  mdu_issue, mdu_issue_idx,
    input  mdu_res_valid, mdu_res_idx, mdu_res_data,
    output mdu_res_ready,
    input  id_rs1_en, id_rs2_en, id_rd_en,
    input  id_rs1_idx, id_rs2_idx, id_rd_idx, id_mdu,
    output wb_rd_en, wb_rd_idx, wb_rd_data, stall
  );

endinterface

// File: rtl/wb_fifo.sv
// Small power-of-2 FIFO holding MDU results {idx, data}.
// Registered count; full/empty derived from it.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t din,
  input  logic      pop,
  output wb_entry_t dout,
  output logic      full,
  output logic      empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Regfile write-port arbiter: pipeline WB has priority, buffered
// MDU results drain into idle slots; scoreboard stalls ID.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH,
  parameter int MAX_OUTST  = MDU_MAX_OUTST
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);

  localparam int OW = $clog2(MAX_OUTST + 1);

  wb_entry_t             head;
  wb_entry_t             din;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  pipe_win;
  logic [NUM_REGS-1:0]   pending;
  logic [NUM_REGS-1:0]   pending_d;
  logic [OW-1:0]         outst;
  logic                  hz_rs1;
  logic                  hz_rs2;
  logic                  hz_rd;
  logic                  no_credit;

  assign din.idx  = bus.mdu_res_idx;
  assign din.data = bus.mdu_res_data;

  assign bus.mdu_res_ready = !full && !rst;
  assign push = bus.mdu_res_valid && bus.mdu_res_ready;

  assign pipe_win = bus.pipe_wb_en && !is_x0(bus.pipe_wb_idx);
  assign pop      = !empty && !pipe_win;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    bus.wb_rd_en   = 1'b0;
    bus.wb_rd_idx  = '0;
    bus.wb_rd_data = '0;
    unique case (1'b1)
      pipe_win: begin
        bus.wb_rd_en   = 1'b1;
        bus.wb_rd_idx  = bus.pipe_wb_idx;
        bus.wb_rd_data = bus.pipe_wb_data;
      end
      pop: begin
        bus.wb_rd_en   = !is_x0(head.idx);
        bus.wb_rd_idx  = head.idx;
        bus.wb_rd_data = head.data;
      end
      default: ;
    endcase
  end

  // Clear first so a same-cycle re-issue to the drained idx wins.
  always_comb begin
    pending_d = pending;
    if (pop) pending_d[head.idx] = 1'b0;
    if (bus.mdu_issue) pending_d[bus.mdu_issue_idx] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      outst   <= '0;
    end else begin
      pending <= pending_d;
      unique case ({bus.mdu_issue, pop})
        2'b10:   outst <= outst + 1'b1;
        2'b01:   outst <= outst - 1'b1;
        default: outst <= outst;
      endcase
      assert (!(pipe_win && pending[bus.pipe_wb_idx]))
        else $error("pipeline write to pending x%0d", bus.pipe_wb_idx);
      assert (!(push && !is_x0(bus.mdu_res_idx)
                && !pending[bus.mdu_res_idx]))
        else $error("MDU result to non-pending x%0d", bus.mdu_res_idx);
      assert (!(pop && !bus.mdu_issue && outst == '0))
        else $error("MDU outstanding count underflow");
    end
  end

  assign hz_rs1    = bus.id_rs1_en && pending[bus.id_rs1_idx];
  assign hz_rs2    = bus.id_rs2_en && pending[bus.id_rs2_idx];
  assign hz_rd     = bus.id_rd_en  && pending[bus.id_rd_idx];
  assign no_credit = bus.id_mdu && (outst == OW'(MAX_OUTST));
  assign bus.stall = hz_rs1 || hz_rs2 || hz_rd || no_credit;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: write-port priority, FIFO drain,
// scoreboard stalls, credit limit, reset flush and x0 handling.
module tb_wb_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  wb_arbiter_if bus ();

  wb_arbiter #(.FIFO_DEPTH(2), .MAX_OUTST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk1(string tag, logic obs, logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %b expected %b", tag, obs, exp);
  endtask

  task automatic chk32(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.pipe_wb_en    = 1'b0;
    bus.pipe_wb_idx   = '0;
    bus.pipe_wb_data  = '0;
    bus.mdu_issue     = 1'b0;
    bus.mdu_issue_idx = '0;
    bus.mdu_res_valid = 1'b0;
    bus.mdu_res_idx   = '0;
    bus.mdu_res_data  = '0;
    bus.id_rs1_en     = 1'b0;
    bus.id_rs2_en     = 1'b0;
    bus.id_rd_en      = 1'b0;
    bus.id_rs1_idx    = '0;
    bus.id_rs2_idx    = '0;
    bus.id_rd_idx     = '0;
    bus.id_mdu        = 1'b0;
  endtask

  task automatic issue(logic [4:0] r);
    nxt(); idle();
    bus.mdu_issue = 1'b1; bus.mdu_issue_idx = r;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk); #1;
    chk1("rst_ready", bus.mdu_res_ready, 1'b0);
    chk1("rst_wb_en", bus.wb_rd_en, 1'b0);
    chk1("rst_stall", bus.stall, 1'b0);
    @(negedge clk); rst = 1'b0; #1;
    chk1("post_rst_ready", bus.mdu_res_ready, 1'b1);
    chk1("post_rst_wb_en", bus.wb_rd_en, 1'b0);

    // pipeline write, same-cycle pass-through
    nxt(); idle();
    bus.pipe_wb_en = 1'b1; bus.pipe_wb_idx = 5'd3;
    bus.pipe_wb_data = 32'hA5A5_0001; #1;
    chk1("t1_en", bus.wb_rd_en, 1'b1);
    chk32("t1_idx", 32'(bus.wb_rd_idx), 32'd3);
    chk32("t1_data", bus.wb_rd_data, 32'hA5A5_0001);
    nxt(); idle();
    bus.pipe_wb_en = 1'b1; bus.pipe_wb_data = 32'hFFFF_FFFF; #1;
    chk1("x0_pipe_no_wr", bus.wb_rd_en, 1'b0);

    // single MDU op to x5
    issue(5'd5); #1;
    chk1("t2_issue_nostall", bus.stall, 1'b0);
    nxt(); idle();
    bus.id_rs1_en = 1'b1; bus.id_rs1_idx = 5'd5; #1;
    chk1("t2_stall_c1", bus.stall, 1'b1);
    nxt(); #1;
    chk1("t2_stall_c2", bus.stall, 1'b1);
    nxt();
    bus.mdu_res_valid = 1'b1; bus.mdu_res_idx = 5'd5;
    bus.mdu_res_data = 32'h12; #1;
    chk1("t2_push_no_wr", bus.wb_rd_en, 1'b0);
    chk1("t2_stall_c3", bus.stall, 1'b1);
    nxt();
    bus.mdu_res_valid = 1'b0; #1;
    chk1("t2_wb_en", bus.wb_rd_en, 1'b1);
    chk32("t2_wb_idx", 32'(bus.wb_rd_idx), 32'd5);
    chk32("t2_wb_data", bus.wb_rd_data, 32'h12);
    chk1("t2_stall_drain", bus.stall, 1'b1);
    nxt(); #1;
    chk1("t2_wb_idle", bus.wb_rd_en, 1'b0);
    chk1("t2_stall_free", bus.stall, 1'b0);

    // pipe busy 4 cycles while two MDU results buffer
    issue(5'd8);
    issue(5'd9);
    nxt(); idle();
    bus.pipe_wb_en = 1'b1; bus.pipe_wb_idx = 5'd10;
    bus.pipe_wb_data = 32'd100;
    bus.mdu_res_valid = 1'b1; bus.mdu_res_idx = 5'd8;
    bus.mdu_res_data = 32'h88; #1;
    chk1("t3_ready_c1", bus.mdu_res_ready, 1'b1);
    chk32("t3_pipe_idx_c1", 32'(bus.wb_rd_idx), 32'd10);
    nxt();
    bus.pipe_wb_idx = 5'd11; bus.pipe_wb_data = 32'd101;
    bus.mdu_res_idx = 5'd9; bus.mdu_res_data = 32'h99;
    bus.id_rs2_en = 1'b1; bus.id_rs2_idx = 5'd8; #1;
    chk1("t3_ready_c2", bus.mdu_res_ready, 1'b1);
    chk32("t3_pipe_data_c2", bus.wb_rd_data, 32'd101);
    chk1("t3_rs2_stall", bus.stall, 1'b1);
    nxt();
    bus.mdu_res_valid = 1'b0; bus.id_rs2_en = 1'b0;
    bus.pipe_wb_idx = 5'd12; bus.pipe_wb_data = 32'd102; #1;
    chk1("t3_full_c3", bus.mdu_res_ready, 1'b0);
    chk32("t3_pipe_idx_c3", 32'(bus.wb_rd_idx), 32'd12);
    nxt();
    bus.pipe_wb_idx = 5'd13; bus.pipe_wb_data = 32'd103; #1;
    chk1("t3_full_c4", bus.mdu_res_ready, 1'b0);
    chk32("t3_pipe_data_c4", bus.wb_rd_data, 32'd103);
    nxt(); idle(); #1;
    chk1("t3_drain1_en", bus.wb_rd_en, 1'b1);
    chk32("t3_drain1_idx", 32'(bus.wb_rd_idx), 32'd8);
    chk32("t3_drain1_data", bus.wb_rd_data, 32'h88);
    chk1("t3_full_c5", bus.mdu_res_ready, 1'b0);
    nxt(); #1;
    chk32("t3_drain2_idx", 32'(bus.wb_rd_idx), 32'd9);
    chk32("t3_drain2_data", bus.wb_rd_data, 32'h99);
    chk1("t3_ready_c6", bus.mdu_res_ready, 1'b1);
    nxt();
    bus.id_rs1_en = 1'b1; bus.id_rs1_idx = 5'd9; #1;
    chk1("t3_empty", bus.wb_rd_en, 1'b0);
    chk1("t3_x9_free", bus.stall, 1'b0);

    // credit limit
    issue(5'd1);
    issue(5'd2);
    issue(5'd3);
    issue(5'd4);
    nxt(); idle();
    bus.id_mdu = 1'b1;
    bus.mdu_res_valid = 1'b1; bus.mdu_res_idx = 5'd1;
    bus.mdu_res_data = 32'h1; #1;
    chk1("t4_credit_stall", bus.stall, 1'b1);
    nxt();
    bus.mdu_res_valid = 1'b0; #1;
    chk32("t4_pop_idx", 32'(bus.wb_rd_idx), 32'd1);
    chk1("t4_stall_pop_cyc", bus.stall, 1'b1);
    nxt(); #1;
    chk1("t4_credit_back", bus.stall, 1'b0);
    bus.id_mdu = 1'b0;
    for (int r = 2; r <= 4; r++) begin
      nxt();
      bus.mdu_res_valid = 1'b1;
      bus.mdu_res_idx = 5'(r); bus.mdu_res_data = 32'(r);
    end
    nxt(); idle();
    nxt();

    // reset with buffered entries and x7 pending
    issue(5'd6);
    issue(5'd7);
    issue(5'd20);
    nxt(); idle();
    bus.pipe_wb_en = 1'b1; bus.pipe_wb_idx = 5'd15;
    bus.mdu_res_valid = 1'b1; bus.mdu_res_idx = 5'd6;
    bus.mdu_res_data = 32'h66;
    nxt();
    bus.pipe_wb_idx = 5'd16;
    bus.mdu_res_idx = 5'd20; bus.mdu_res_data = 32'h20;
    nxt();
    bus.mdu_res_valid = 1'b0; bus.pipe_wb_idx = 5'd17;
    bus.id_rs1_en = 1'b1; bus.id_rs1_idx = 5'd7; #1;
    chk1("t5_pre_full", bus.mdu_res_ready, 1'b0);
    chk1("t5_pre_stall", bus.stall, 1'b1);
    rst = 1'b1; bus.pipe_wb_en = 1'b0; #1;
    chk1("t5_rst_wb_en", bus.wb_rd_en, 1'b0);
    chk1("t5_rst_stall", bus.stall, 1'b0);
    chk1("t5_rst_ready", bus.mdu_res_ready, 1'b0);
    nxt();
    rst = 1'b0; bus.id_mdu = 1'b1; #1;
    chk1("t5_empty", bus.wb_rd_en, 1'b0);
    chk1("t5_ready", bus.mdu_res_ready, 1'b1);
    chk1("t5_stall", bus.stall, 1'b0);

    // MDU op to x0 still consumes a credit
    issue(5'd0);
    nxt(); idle();
    bus.id_rs1_en = 1'b1; bus.id_rs1_idx = 5'd0; #1;
    chk1("t6_x0_nostall", bus.stall, 1'b0);
    bus.mdu_issue = 1'b1; bus.mdu_issue_idx = 5'd1;
    issue(5'd2);
    issue(5'd3);
    nxt(); idle();
    bus.id_mdu = 1'b1;
    bus.mdu_res_valid = 1'b1; bus.mdu_res_idx = 5'd0;
    bus.mdu_res_data = 32'hDEAD; #1;
    chk1("t6_credit_stall", bus.stall, 1'b1);
    nxt();
    bus.mdu_res_valid = 1'b0; #1;
    chk1("t6_x0_no_wr", bus.wb_rd_en, 1'b0);
    chk1("t6_stall_pop_cyc", bus.stall, 1'b1);
    nxt(); #1;
    chk1("t6_credit_back", bus.stall, 1'b0);
    chk1("t6_idle", bus.wb_rd_en, 1'b0);
    bus.id_mdu = 1'b0;
    for (int r = 1; r <= 3; r++) begin
      nxt();
      bus.mdu_res_valid = 1'b1;
      bus.mdu_res_idx = 5'(r); bus.mdu_res_data = 32'(r);
    end
    nxt(); idle();
    nxt(); #1;
    chk1("end_idle", bus.wb_rd_en, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
